// File: rtl/st_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : st_pkg                                                      |
// | Desc   : Shared constants and state type for the stack-op sequencer. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package st_pkg;

    localparam logic ST_OP_PUSH = 1'b0;
    localparam logic ST_OP_POP  = 1'b1;

    localparam int REG_LIST_W = 9;
    localparam int LR_PC_BIT  = 8;
    localparam int REG_IDX_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PUSH   = 3'd1,
        ST_POP    = 3'd2,
        ST_POP_WB = 3'd3,
        ST_DONE   = 3'd4
    } st_state_t;

endpackage : st_pkg
`default_nettype wire

// File: rtl/st_reglist_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : st_reglist_enc                                              |
// | Desc   : Register-list priority encoder: lowest set bit, its one-hot |
// |          clear mask, and the population count of the list.           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module st_reglist_enc
    import st_pkg::*;
(
    input  logic [REG_LIST_W-1:0] mask,
    output logic [REG_IDX_W-1:0]  low_idx,
    output logic [REG_LIST_W-1:0] low_onehot,
    output logic [REG_IDX_W-1:0]  count
);

    logic w_found;

    always_comb begin
        low_idx    = '0;
        low_onehot = '0;
        count      = '0;
        w_found    = 1'b0;
        for (int i = 0; i < REG_LIST_W; i++) begin
            if (mask[i]) begin
                count = count + 4'd1;
                if (!w_found) begin
                    low_idx       = 4'(i);
                    low_onehot[i] = 1'b1;
                    w_found       = 1'b1;
                end
            end
        end
    end

endmodule : st_reglist_enc
`default_nettype wire

// File: rtl/st_pushpop_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : st_pushpop_seq                                              |
// | Desc   : Multi-cycle PUSH/POP register-list sequencer owning the SP. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module st_pushpop_seq
    import st_pkg::*;
#(
    parameter logic [15:0] SP_INIT   = 16'h0100,
    parameter int          ADDR_STEP = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  op,
    input  logic [REG_LIST_W-1:0] reg_list,
    input  logic                  sp_wr,
    input  logic [15:0]           sp_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           dmem_addr,
    output logic                  dmem_wr,
    output logic                  dmem_rd,
    output logic [2:0]            rf_raddr,
    output logic                  lr_sel,
    output logic [2:0]            rf_waddr,
    output logic                  rf_wr,
    output logic                  pc_wr,
    output logic [15:0]           sp_out
);

    localparam logic [15:0] c_STEP = 16'(ADDR_STEP);

    st_state_t             r_state;
    logic [15:0]           r_sp;
    logic [REG_LIST_W-1:0] r_mask;
    logic [REG_IDX_W-1:0]  r_cnt;
    logic [REG_IDX_W-1:0]  r_k;
    logic                  r_wb_valid;
    logic [REG_IDX_W-1:0]  r_wb_idx;

    logic [REG_LIST_W-1:0] w_enc_in;
    logic [REG_IDX_W-1:0]  w_idx;
    logic [REG_LIST_W-1:0] w_clr;
    logic [REG_IDX_W-1:0]  w_cnt;
    logic [REG_LIST_W-1:0] w_mask_next;
    logic [15:0]           w_off_k;
    logic [15:0]           w_off_n;
    logic [15:0]           w_off_new;

    // One encoder serves both roles: counting the incoming list while idle,
    // and picking the next register from the remaining mask while busy.
    assign w_enc_in    = (r_state == ST_IDLE) ? reg_list : r_mask;
    assign w_mask_next = r_mask & ~w_clr;
    assign w_off_k     = 16'(r_k) * c_STEP;
    assign w_off_n     = 16'(r_cnt) * c_STEP;
    assign w_off_new   = 16'(w_cnt) * c_STEP;

    st_reglist_enc u_enc (
        .mask       (w_enc_in),
        .low_idx    (w_idx),
        .low_onehot (w_clr),
        .count      (w_cnt)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_sp       <= SP_INIT;
            r_mask     <= '0;
            r_cnt      <= '0;
            r_k        <= '0;
            r_wb_valid <= 1'b0;
            r_wb_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mask     <= reg_list;
                        r_cnt      <= w_cnt;
                        r_k        <= '0;
                        r_wb_valid <= 1'b0;
                        if (w_cnt == '0) begin
                            r_state <= ST_DONE;
                        end else if (op == ST_OP_PUSH) begin
                            r_sp    <= r_sp - w_off_new;
                            r_state <= ST_PUSH;
                        end else begin
                            r_state <= ST_POP;
                        end
                    end else if (sp_wr) begin
                        r_sp <= sp_wdata;
                    end
                end
                ST_PUSH: begin
                    r_mask <= w_mask_next;
                    r_k    <= r_k + 4'd1;
                    if (w_mask_next == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_POP: begin
                    // Load data returns next cycle, so the write select trails by one.
                    r_mask     <= w_mask_next;
                    r_k        <= r_k + 4'd1;
                    r_wb_valid <= 1'b1;
                    r_wb_idx   <= w_idx;
                    if (w_mask_next == '0) begin
                        r_state <= ST_POP_WB;
                    end
                end
                ST_POP_WB: begin
                    r_wb_valid <= 1'b0;
                    r_sp       <= r_sp + w_off_n;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy      = (r_state == ST_PUSH) || (r_state == ST_POP) || (r_state == ST_POP_WB);
        done      = (r_state == ST_DONE);
        dmem_wr   = (r_state == ST_PUSH);
        dmem_rd   = (r_state == ST_POP);
        dmem_addr = 16'h0000;
        rf_raddr  = 3'd0;
        lr_sel    = 1'b0;
        rf_wr     = 1'b0;
        pc_wr     = 1'b0;
        rf_waddr  = 3'd0;
        sp_out    = r_sp;
        if (dmem_wr || dmem_rd) begin
            dmem_addr = r_sp + w_off_k;
        end
        if (dmem_wr) begin
            if (w_idx == 4'(LR_PC_BIT)) begin
                lr_sel = 1'b1;
            end else begin
                rf_raddr = w_idx[2:0];
            end
        end
        if (r_wb_valid) begin
            if (r_wb_idx == 4'(LR_PC_BIT)) begin
                pc_wr = 1'b1;
            end else begin
                rf_wr    = 1'b1;
                rf_waddr = r_wb_idx[2:0];
            end
        end
    end

endmodule : st_pushpop_seq
`default_nettype wire

// File: tb/tb_st_pushpop_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_st_pushpop_seq                                           |
// | Desc   : Scoreboard bench for the stack-op sequencer.                |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_st_pushpop_seq;
    import st_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        op;
    logic [8:0]  reg_list;
    logic        sp_wr;
    logic [15:0] sp_wdata;
    logic        busy, done, dmem_wr, dmem_rd, lr_sel, rf_wr, pc_wr;
    logic [15:0] dmem_addr, sp_out;
    logic [2:0]  rf_raddr, rf_waddr;

    always #5 clk = ~clk;

    st_pushpop_seq dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .reg_list  (reg_list),
        .sp_wr     (sp_wr),
        .sp_wdata  (sp_wdata),
        .busy      (busy),
        .done      (done),
        .dmem_addr (dmem_addr),
        .dmem_wr   (dmem_wr),
        .dmem_rd   (dmem_rd),
        .rf_raddr  (rf_raddr),
        .lr_sel    (lr_sel),
        .rf_waddr  (rf_waddr),
        .rf_wr     (rf_wr),
        .pc_wr     (pc_wr),
        .sp_out    (sp_out)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        wr;
        logic        rd;
        logic        lr;
        logic        rfw;
        logic        pcw;
        logic [15:0] addr;
        logic [2:0]  ra;
        logic [2:0]  wa;
        logic [15:0] sp;
    } obs_t;

    obs_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_sp;

    function automatic obs_t sample();
        obs_t o;
        o      = '0;
        o.busy = busy;
        o.done = done;
        o.wr   = dmem_wr;
        o.rd   = dmem_rd;
        o.lr   = lr_sel;
        o.rfw  = rf_wr;
        o.pcw  = pc_wr;
        o.addr = dmem_addr;
        o.ra   = rf_raddr;
        o.wa   = rf_waddr;
        o.sp   = sp_out;
        return o;
    endfunction

    function automatic obs_t idle_obs(input logic [15:0] sp);
        obs_t o;
        o    = '0;
        o.sp = sp;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("busy=%b done=%b wr=%b rd=%b addr=%h ra=%0d lr=%b rfw=%b wa=%0d pcw=%b sp=%h",
                         o.busy, o.done, o.wr, o.rd, o.addr, o.ra, o.lr, o.rfw, o.wa, o.pcw, o.sp);
    endfunction

    // Expected per-cycle trace from cycle 1 through the idle cycle after done.
    task automatic build_expect(input logic o, input logic [8:0] lst);
        int   idx[$];
        int   n;
        obs_t e;
        logic [15:0] base;
        for (int b = 0; b < 9; b++) if (lst[b]) idx.push_back(b);
        n = idx.size();
        if (n == 0) begin
            e = '0; e.done = 1'b1; e.sp = m_sp;
            exp_q.push_back(e);
        end else if (o == ST_OP_PUSH) begin
            base = m_sp - 16'(n);
            for (int k = 0; k < n; k++) begin
                e = '0; e.busy = 1'b1; e.wr = 1'b1; e.sp = base;
                e.addr = base + 16'(k);
                if (idx[k] == 8) e.lr = 1'b1;
                else             e.ra = 3'(idx[k]);
                exp_q.push_back(e);
            end
            m_sp = base;
            e = '0; e.done = 1'b1; e.sp = m_sp;
            exp_q.push_back(e);
        end else begin
            for (int c = 1; c <= n + 1; c++) begin
                e = '0; e.busy = 1'b1; e.sp = m_sp;
                if (c <= n) begin
                    e.rd = 1'b1; e.addr = m_sp + 16'(c - 1);
                end
                if (c >= 2) begin
                    if (idx[c-2] == 8) e.pcw = 1'b1;
                    else begin e.rfw = 1'b1; e.wa = 3'(idx[c-2]); end
                end
                exp_q.push_back(e);
            end
            m_sp = m_sp + 16'(n);
            e = '0; e.done = 1'b1; e.sp = m_sp;
            exp_q.push_back(e);
        end
        exp_q.push_back(idle_obs(m_sp));
    endtask

    // disturb: 0 none, 1 re-assert start while running, 2 assert sp_wr while running
    task automatic run_op(input string name, input logic o, input logic [8:0] lst,
                          input int disturb, input logic with_spwr);
        obs_t got, e;
        int   cyc;
        build_expect(o, lst);
        @(negedge clk);
        start = 1'b1; op = o; reg_list = lst;
        if (with_spwr) begin sp_wr = 1'b1; sp_wdata = 16'hBEEF; end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            got = sample();
            e   = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got %s required %s", name, cyc, fmt(got), fmt(e));
            end
            start = 1'b0; sp_wr = 1'b0;
            op = 1'($urandom); reg_list = 9'($urandom);
            if (exp_q.size() > 0) begin
                if (disturb == 1) start = 1'b1;
                else if (disturb == 2) begin sp_wr = 1'b1; sp_wdata = 16'($urandom); end
            end
        end
        start = 1'b0; sp_wr = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        resetn = 1'b1; start = 1'b0; op = 1'b0; reg_list = '0; sp_wr = 1'b0; sp_wdata = '0;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        m_sp = 16'h0100;
        got = sample();
        n_checks++;
        if (got !== idle_obs(m_sp)) begin
            n_errors++;
            $display("FAIL reset_held: got %s required %s", fmt(got), fmt(idle_obs(m_sp)));
        end
        resetn = 1'b1;
        @(negedge clk);
        got = sample();
        n_checks++;
        if (got !== idle_obs(m_sp)) begin
            n_errors++;
            $display("FAIL reset_release: got %s required %s", fmt(got), fmt(idle_obs(m_sp)));
        end
    endtask

    task automatic test_push();
        run_op("push_r1_r3_lr", ST_OP_PUSH, 9'b1_0000_1010, 0, 1'b0);
    endtask

    task automatic test_pop();
        run_op("pop_r0_r2_pc", ST_OP_POP, 9'b1_0000_0101, 0, 1'b0);
    endtask

    task automatic test_empty();
        run_op("empty_push", ST_OP_PUSH, 9'h000, 0, 1'b0);
        run_op("empty_pop",  ST_OP_POP,  9'h000, 0, 1'b0);
    endtask

    task automatic test_wrap();
        obs_t got;
        @(negedge clk);
        sp_wr = 1'b1; sp_wdata = 16'h0001;
        @(negedge clk);
        sp_wr = 1'b0;
        m_sp = 16'h0001;
        got = sample();
        n_checks++;
        if (got !== idle_obs(m_sp)) begin
            n_errors++;
            $display("FAIL sp_load: got %s required %s", fmt(got), fmt(idle_obs(m_sp)));
        end
        run_op("push_all_wrap", ST_OP_PUSH, 9'h1FF, 0, 1'b0);
        run_op("pop_all_wrap",  ST_OP_POP,  9'h1FF, 0, 1'b0);
    endtask

    task automatic test_ignored();
        run_op("push_start_ignored", ST_OP_PUSH, 9'b0_1100_0110, 1, 1'b0);
        run_op("pop_spwr_ignored",   ST_OP_POP,  9'b0_1100_0110, 2, 1'b0);
        run_op("start_beats_spwr",   ST_OP_PUSH, 9'b1_1000_0001, 0, 1'b1);
        run_op("pop_after_collide",  ST_OP_POP,  9'b1_1000_0001, 0, 1'b0);
    endtask

    task automatic test_reset_midop();
        obs_t got, e;
        @(negedge clk);
        start = 1'b1; op = ST_OP_PUSH; reg_list = 9'h01F;
        @(negedge clk);
        start = 1'b0;
        e = '0; e.busy = 1'b1; e.wr = 1'b1; e.addr = m_sp - 16'd5; e.sp = m_sp - 16'd5;
        got = sample();
        n_checks++;
        if (got !== e) begin
            n_errors++;
            $display("FAIL midop_cycle1: got %s required %s", fmt(got), fmt(e));
        end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        m_sp = 16'h0100;
        got = sample();
        n_checks++;
        if (got !== idle_obs(m_sp)) begin
            n_errors++;
            $display("FAIL midop_reset: got %s required %s", fmt(got), fmt(idle_obs(m_sp)));
        end
        @(negedge clk);
        resetn = 1'b1;
        run_op("push_after_reset", ST_OP_PUSH, 9'h01F, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop();
        test_empty();
        test_wrap();
        test_ignored();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_st_pushpop_seq
`default_nettype wire

// File: doc/st_pushpop_seq.md
Name: st_pushpop_seq

Overview:
- Multi-cycle sequencer for PUSH/POP register-list stack instructions in the dsd_processor stack unit.
- Owns the stack pointer and walks the 9-bit register list one transfer per cycle, driving data-memory address/strobes and register-file read/write selects.
- Stalls the core while busy, then pulses done.
- Full-descending stack: push pre-decrements, pop post-increments.

Parameters:
- SP_INIT, 16'h0100, stack pointer reset value
- ADDR_STEP, 1, dmem address increment per transferred register (word-addressed dmem)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request a stack op; accepted only in IDLE
- op  in  1  0=PUSH, 1=POP; sampled with start
- reg_list  in  9  [7:0]=r0..r7; [8]=LR for PUSH, PC for POP; sampled with start
- sp_wr  in  1  load SP from sp_wdata (MOV SP); honoured only in IDLE without start
- sp_wdata  in  16  new SP value
- busy  out  1  op in progress; core must stall
- done  out  1  one-cycle completion pulse
- dmem_addr  out  16  data memory address
- dmem_wr  out  1  store strobe (PUSH)
- dmem_rd  out  1  load strobe (POP); dmem read data valid next cycle
- rf_raddr  out  3  register-file read select for the push source
- lr_sel  out  1  push source is LR instead of rf_raddr
- rf_waddr  out  3  register-file write select for pop data
- rf_wr  out  1  register-file write strobe
- pc_wr  out  1  write popped data to PC
- sp_out  out  16  current SP

Behaviour:
- Reset (async, any state): state=IDLE, SP=SP_INIT, all strobes/busy/done=0, addresses/selects=0.
- States: IDLE, PUSH, POP, POP_WB (final write-back), DONE.
- N = popcount(reg_list), 0..9.
- Accept, cycle 0: start=1 in IDLE.
  - Latch op, mask and N.
  - PUSH with N>0: SP <= SP - N*ADDR_STEP on the cycle-0 edge; next state PUSH.
  - POP with N>0: next state POP; SP unchanged until the end.
- Empty list (N=0): go straight to DONE; no memory or register access, SP unchanged.
- PUSH, cycles 1..N:
  - dmem_wr=1; dmem_addr = SP + k*ADDR_STEP, k=0..N-1.
  - Source is the lowest set bit of the remaining mask. Bits 0..7 drive rf_raddr; bit 8 gives lr_sel=1 with rf_raddr=0.
  - Clear the bit each cycle. After the last transfer go to DONE.
- POP, cycles 1..N: dmem_rd=1; dmem_addr = SP + k*ADDR_STEP, lowest set bit first.
- POP write-back is pipelined one cycle behind the address:
  - In cycle k+1, rf_wr=1 with rf_waddr = the register addressed in cycle k.
  - If that register is bit 8: pc_wr=1, rf_wr=0.
- POP_WB (cycle N+1): final write-back only, no dmem_rd. SP <= SP + N*ADDR_STEP on this edge; next state DONE.
- DONE, one cycle: done=1, busy=0; return to IDLE.
- Latency: PUSH done at cycle N+1, POP done at cycle N+2, empty list done at cycle 1.
- busy = 1 in PUSH, POP and POP_WB. The strobes are Moore outputs decoded from registered state, mask and pipeline registers.
- start while not IDLE is ignored (not queued). start in the DONE cycle is also ignored.
- start and sp_wr in the same IDLE cycle: start wins, sp_wr is dropped. sp_wr outside IDLE is ignored.
- sp_wr accepted: sp_out shows sp_wdata from the next cycle.
- SP arithmetic is modulo 2^16; wrap-around is silent, no fault.
- op and reg_list are don't-care when start=0. Changes during busy have no effect.
- Reset mid-operation aborts immediately: partial stores remain in memory and SP reverts to SP_INIT.

Decomposition:
- Shared package st_pkg:
  - ST_OP_PUSH=1'b0, ST_OP_POP=1'b1
  - REG_LIST_W=9, LR_PC_BIT=8
  - state encoding constants
- Sub-module st_reglist_enc (combinational): 9-bit mask in; lowest-set-bit index, one-hot clear mask and popcount out. Used for both N at accept and per-cycle selection.

Test Plan:
- PUSH {r1,r3,LR}, SP=0x0100:
  - sp_out=0x00FD from cycle 1.
  - dmem_wr at addr 0x00FD/0x00FE/0x00FF with rf_raddr 1, 3, then lr_sel=1.
  - done at cycle 4.
- POP {r0,r2,PC}, SP=0x00FD:
  - dmem_rd at 0x00FD..0x00FF in cycles 1-3.
  - rf_wr waddr 0 in cycle 2, waddr 2 in cycle 3; pc_wr in cycle 4.
  - SP=0x0100 and done=1 in cycle 5.
- reg_list=0, either op: done at cycle 1; no strobes; SP unchanged.
- sp_wr=1 with sp_wdata=0x0001, then PUSH of all 9 bits:
  - SP wraps to 0xFFF8.
  - Addresses 0xFFF8..0x0000 in r0..r7, LR order; done at cycle 10.
- start re-asserted mid-PUSH, and sp_wr mid-POP: both ignored, trace identical to the clean run. start+sp_wr in the same IDLE cycle: push proceeds on the old SP.
- resetn low in cycle 2 of a 5-register PUSH: outputs 0 at once, SP=0x0100, state IDLE; a new start after release runs normally.
